// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store sequencer:
//   - lsu_state_e : sequencer states
//   - F3_*        : RV32I load/store funct3 width/sign codes
//   - WORD_W      : memory word width (only 32 is supported)
//   - is_misaligned / is_illegal : request classification helpers
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CAP   = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Halfword needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (funct3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
    function automatic logic is_illegal(input logic       we,
                                        input logic [2:0] funct3);
        logic ill;
        case (funct3)
            F3_B, F3_H, F3_W: ill = 1'b0;
            F3_BU, F3_HU:     ill = we;
            default:          ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store sequencer.
//   funct3     in  : width/sign code of the access
//   addr_lo    in  : byte offset within the word
//   rdata      in  : word read from memory
//   wdata      in  : right-aligned store payload
//   load_data  out : selected lane, sign/zero extended
//   merge_data out : read word with the store payload merged at its lane
// Halfword lanes are chosen by addr_lo[1] alone so that, when misalignment
// is not trapped, addr_lo[0] is simply ignored.
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] rdata,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merge_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Load lane extraction and extension
    always_comb begin
        byte_s = rdata[{addr_lo, 3'b000} +: 8];
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (funct3)
            F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
            F3_BU:   load_data = {24'h000000, byte_s};
            F3_H:    load_data = {{16{half_s[15]}}, half_s};
            F3_HU:   load_data = {16'h0000, half_s};
            F3_W:    load_data = rdata;
            default: load_data = rdata;
        endcase
    end

    // Store lane merge into the read word
    always_comb begin
        merge_data = rdata;
        case (funct3[1:0])
            2'b00: begin
                merge_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            2'b01: begin
                if (addr_lo[1]) begin
                    merge_data[31:16] = wdata[15:0];
                end else begin
                    merge_data[15:0] = wdata[15:0];
                end
            end
            default: begin
                merge_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
// Load/store sequencer in front of a word-wide, synchronous-read data memory.
// Byte/halfword stores become read-modify-write; loads are lane-extracted and
// extended. The core is stalled through o_busy until o_done.
//
// Ports:
//   i_clk, i_reset     : clock (rising edge), async active-low reset
//   i_req/i_we/i_funct3/i_addr/i_wdata : request, sampled only in IDLE
//   o_rdata            : extended load result, held until the next load
//   o_done/o_err       : one-cycle completion pulse and its error flag
//   o_busy             : high from the cycle after acceptance to o_done
//   o_mem_addr/o_mem_wdata/o_mem_wren : dmem word address, data, write enable
//   i_mem_rdata        : dmem registered read data
//
// Configuration macro:
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned halfword/word accesses
//                          complete with o_err=1. When undefined, halfwords
//                          use addr[1] only and words ignore addr[1:0].
//
// All outputs are registered; they are computed from the next state so that
// their timing matches the state they belong to.
// -----------------------------------------------------------------------------
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_done,
    output logic              o_err,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_wren,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    lsu_state_e        state_r;
    lsu_state_e        next_state_s;

    logic [2:0]        funct3_r;
    logic              we_r;
    logic [1:0]        addr_lo_r;
    logic [DATA_W-1:0] wdata_r;

    logic              accept_s;
    logic              illegal_s;
    logic              misal_s;
    logic              req_err_s;
    logic [DATA_W-1:0] load_s;
    logic [DATA_W-1:0] merge_s;

    // Request classification at the IDLE sampling point
    always_comb begin
        accept_s  = (state_r == IDLE) && i_req;
        illegal_s = is_illegal(i_we, i_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        misal_s   = is_misaligned(i_funct3, i_addr[1:0]);
`else
        misal_s   = 1'b0;
`endif
        req_err_s = illegal_s | misal_s;
    end

    // Sequencer state register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Sequencer next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (req_err_s) begin
                        next_state_s = RESP;
                    end else if (i_we && (i_funct3 == F3_W)) begin
                        next_state_s = WRITE;
                    end else begin
                        next_state_s = READ;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            READ:    next_state_s = CAP;
            CAP: begin
                if (we_r) begin
                    next_state_s = WRITE;
                end else begin
                    next_state_s = RESP;
                end
            end
            WRITE:   next_state_s = RESP;
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    lsu_align u_align (
        .funct3     (funct3_r),
        .addr_lo    (addr_lo_r),
        .rdata      (i_mem_rdata),
        .wdata      (wdata_r),
        .load_data  (load_s),
        .merge_data (merge_s)
    );

    // Request latches, registered outputs and the RMW write buffer
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            funct3_r    <= 3'b000;
            we_r        <= 1'b0;
            addr_lo_r   <= 2'b00;
            wdata_r     <= {DATA_W{1'b0}};
            o_rdata     <= {DATA_W{1'b0}};
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
            o_mem_addr  <= {ADDR_W{1'b0}};
            o_mem_wdata <= {DATA_W{1'b0}};
            o_mem_wren  <= 1'b0;
        end else begin
            o_busy     <= (next_state_s != IDLE);
            o_done     <= (next_state_s == RESP);
            // Only an erroring request goes straight from IDLE to RESP.
            o_err      <= (state_r == IDLE) && (next_state_s == RESP);
            o_mem_wren <= (next_state_s == WRITE);

            if (accept_s) begin
                funct3_r  <= i_funct3;
                we_r      <= i_we;
                addr_lo_r <= i_addr[1:0];
                wdata_r   <= i_wdata;
                // Erroring requests leave the memory interface untouched.
                if (!req_err_s) begin
                    o_mem_addr <= {i_addr[ADDR_W-1:2], 2'b00};
                end
                if (!req_err_s && i_we && (i_funct3 == F3_W)) begin
                    o_mem_wdata <= i_wdata;
                end
            end

            if (state_r == CAP) begin
                if (we_r) begin
                    o_mem_wdata <= merge_s;
                end else begin
                    o_rdata <= load_s;
                end
            end
        end
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer directly upstream of the word-wide, synchronous-read data memory (dmem).
- Accepts RV32I load/store requests from the core: LB/LH/LW/LBU/LHU/SB/SH/SW.
- Turns byte/halfword stores into read-modify-write word accesses, and extracts plus sign/zero-extends load data.
- Stalls the core through o_busy until each access completes.

Parameters:
- ADDR_W, 32, core and memory address width.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  reset, asynchronous, active-low.
- i_req  in  1  request strobe; sampled only in IDLE.
- i_we  in  1  1 = store, 0 = load.
- i_funct3  in  3  RV32I width/sign code.
- i_addr  in  32  byte address.
- i_wdata  in  32  store data; the payload is right-aligned.
- o_rdata  out  32  extended load result; valid while o_done=1.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  valid with o_done; marks a misaligned access or illegal funct3.
- o_busy  out  1  high from the cycle after acceptance until the o_done cycle, inclusive.
- o_mem_addr  out  32  word address to dmem, {addr[31:2],2'b00}.
- o_mem_wdata  out  32  word to write.
- o_mem_wren  out  1  dmem write enable.
- i_mem_rdata  in  32  dmem registered read data.

Behaviour:
- Reset (i_reset=0, async):
  - State goes to IDLE.
  - All outputs are 0.
  - Request registers are cleared.
  - Reset mid-operation abandons the access. A pending RMW write is never issued.
- IDLE:
  - o_busy=0.
  - On i_req=1, latch addr, funct3, we and wdata.
  - Check the request:
    - Illegal funct3 (load 011/110/111, store 011–111) -> RESP with err.
    - Misaligned (halfword with addr[0]=1, word with addr[1:0]≠0) -> RESP with err.
    - Otherwise: SW -> WRITE; every other legal access -> READ.
- READ:
  - o_mem_addr = word address, o_mem_wren=0.
  - dmem captures the read at the next edge -> CAP.
- CAP: i_mem_rdata is valid.
  - Load: extract the lane selected by addr[1:0], extend it per funct3 (LB/LH sign, LBU/LHU zero), register into o_rdata -> RESP.
  - SB/SH: merge wdata[7:0] / wdata[15:0] into the read word at the byte lane, register into the write buffer -> WRITE.
- WRITE:
  - o_mem_wren=1 for exactly one cycle, with o_mem_addr and o_mem_wdata stable.
  - SW data is wdata unchanged -> RESP.
- RESP:
  - o_done=1 for one cycle, o_err as determined, o_busy=1 -> IDLE.
  - o_rdata holds its value until the next load completes.
  - Stores leave o_rdata unchanged.
- Latency (accept edge to o_done cycle):
  - Error: 1.
  - SW: 2.
  - Loads: 3.
  - SB/SH: 4.
- Back-to-back: i_req in the cycle after RESP is accepted. i_req while busy is ignored, and the core must hold it.
- o_mem_wren is 0 in every state except WRITE, so dmem sees read mode otherwise.
- An error never touches memory.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned access reports o_err=1, as described above.
- LSU_MISALIGN_TRAP_EN undefined:
  - The misalignment check is removed.
  - Halfword uses addr[1] only, with addr[0] ignored; word ignores addr[1:0].
  - o_err is raised only for illegal funct3.

Decomposition:
- Shared package lsu_pkg holds:
  - State enum lsu_state_e {IDLE, READ, CAP, WRITE, RESP}.
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - Helper function is_misaligned.
- One natural sub-module, lsu_align: purely combinational load lane extract/extend and store lane merge, instantiated once in CAP datapath.

Test Plan:
- Setup: memory word 0x10 = 0x8899AABB.
- LB addr 0x13 -> o_rdata=0xFFFFFF88, o_err=0, o_done 3 cycles after accept.
- LBU addr 0x13 -> 0x00000088.
- LHU addr 0x12 -> 0x00008899.
- SB addr 0x11, wdata 0x000000CC -> exactly one wren pulse with wdata 0x8899CCBB at word 0x10. Follow-up LW 0x10 returns 0x8899CCBB. o_done 4 cycles after accept.
- SW addr 0x20, wdata 0xDEADBEEF -> wren in the cycle after accept, o_done 2 cycles after accept.
- LH addr 0x11:
  - Macro defined: o_done+o_err next cycle, no wren.
  - Macro undefined: returns the halfword at addr 0x10 (0xFFFFAABB before the SB, 0xFFFFCCBB after it).
- Assert i_reset=0 during CAP of an SH -> outputs zero immediately, no wren ever issued, memory word unchanged.
- Hold i_req high through busy -> second access accepted only in the cycle after RESP.
